// File: rtl/test_halt_monitor_if.sv
// Handshake bundle between the core-side tap (master) and the halt monitor (slave).
// The master drives the instruction/a0 taps and start; the slave returns status.
interface test_halt_monitor_if;
    logic        start;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] a0_value;
    logic        busy;
    logic        done;
    logic        done_pulse;
    logic        pass;
    logic        fail;
    logic        unknown;
    logic        timeout;
    logic [31:0] result;
    logic [31:0] cycle_count;

    modport master (
        output start, inst_valid, inst, a0_value,
        input  busy, done, done_pulse, pass, fail, unknown, timeout, result, cycle_count
    );

    modport slave (
        input  start, inst_valid, inst, a0_value,
        output busy, done, done_pulse, pass, fail, unknown, timeout, result, cycle_count
    );
endinterface

// File: rtl/test_halt_monitor.sv
// Test-completion monitor: detects the halt word, captures a0, classifies the
// verdict and enforces a run-length watchdog. All outputs are registered.
module test_halt_monitor #(
    parameter logic [31:0] HALT_INST  = 32'hDEAD10CC,
    parameter logic [31:0] PASS_MAGIC = 32'h00C0FFEE,
    parameter logic [31:0] FAIL_MAGIC = 32'hDEADDEAD,
    parameter int unsigned MAX_CYCLES = 10000
) (
    input  logic                clk,
    input  logic                rst,
    test_halt_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [31:0] LP_LAST = 32'(MAX_CYCLES - 1);
    localparam logic [31:0] LP_MAX  = 32'(MAX_CYCLES);

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_done_pulse;
    logic        r_pass;
    logic        r_fail;
    logic        r_unknown;
    logic        r_timeout;
    logic [31:0] r_result;
    logic [31:0] r_cycle_count;

    logic w_halt_seen;
    logic w_is_pass;
    logic w_is_fail;

    assign w_halt_seen = bus.inst_valid && (bus.inst == HALT_INST);
    assign w_is_pass   = (bus.a0_value == PASS_MAGIC);
    assign w_is_fail   = (bus.a0_value == FAIL_MAGIC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_done_pulse  <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_unknown     <= 1'b0;
            r_timeout     <= 1'b0;
            r_result      <= 32'd0;
            r_cycle_count <= 32'd0;
        end else begin
            r_done_pulse <= 1'b0;
            // start has top priority in every state, including a restart from RUN
            if (bus.start) begin
                r_state       <= ST_RUN;
                r_busy        <= 1'b1;
                r_done        <= 1'b0;
                r_pass        <= 1'b0;
                r_fail        <= 1'b0;
                r_unknown     <= 1'b0;
                r_timeout     <= 1'b0;
                r_result      <= 32'd0;
                r_cycle_count <= 32'd0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_halt_seen) begin
                            r_state      <= ST_HALTED;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_done_pulse <= 1'b1;
                            r_result     <= bus.a0_value;
                            r_pass       <= w_is_pass;
                            r_fail       <= w_is_fail;
                            r_unknown    <= !w_is_pass && !w_is_fail;
                        end else if (r_cycle_count == LP_LAST) begin
                            r_state       <= ST_TIMEOUT;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_done_pulse  <= 1'b1;
                            r_timeout     <= 1'b1;
                            r_cycle_count <= LP_MAX;
                        end else begin
                            r_cycle_count <= r_cycle_count + 32'd1;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.done_pulse  = r_done_pulse;
    assign bus.pass        = r_pass;
    assign bus.fail        = r_fail;
    assign bus.unknown     = r_unknown;
    assign bus.timeout     = r_timeout;
    assign bus.result      = r_result;
    assign bus.cycle_count = r_cycle_count;

endmodule
